// File: rtl/exe_div_ctrl_pkg.sv
// Shared types and widths for the EXE-stage divide sequencer.
package exe_div_ctrl_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Per-request controls captured on acceptance
  typedef struct packed {
    logic q_neg;
    logic r_neg;
    logic rem;
  } div_op_t;

endpackage

// File: rtl/exe_div_ctrl_if.sv
// EXE <-> divider handshake: request/operands in, status/result out.
interface exe_div_ctrl_if
  import exe_div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) ();

  logic              div_req;
  logic              div_signed;
  logic              div_rem;
  logic [DATA_W-1:0] div_src1;
  logic [DATA_W-1:0] div_src2;
  logic              div_cancel;
  logic              mem_allowin;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_result;

  modport master (
    output div_req, div_signed, div_rem, div_src1, div_src2, div_cancel, mem_allowin,
    input  div_busy, div_done, div_result
  );

  modport slave (
    input  div_req, div_signed, div_rem, div_src1, div_src2, div_cancel, mem_allowin,
    output div_busy, div_done, div_result
  );

endinterface

// File: rtl/exe_div_ctrl_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] r_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] r_c_o,
  output logic [DATA_W-1:0] q_c_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // R stays below D, so the restored remainder always fits DATA_W bits
  always_comb begin
    shifted = {r_i, q_i[DATA_W-1]};
    trial   = shifted - {1'b0, d_i};
    if (!trial[DATA_W]) begin
      r_c_o = trial[DATA_W-1:0];
      q_c_o = {q_i[DATA_W-2:0], 1'b1};
    end else begin
      r_c_o = shifted[DATA_W-1:0];
      q_c_o = {q_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exe_div_ctrl.sv
// EXE-stage divide sequencer: one quotient bit per cycle, result held until EXE fires.
module exe_div_ctrl
  import exe_div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned CNT_W  = DIV_CNT_W
) (
  input  logic          clk,
  input  logic          resetn,
  exe_div_ctrl_if.slave div
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] d_q, d_d;
  div_op_t           op_q, op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              s1_neg_c, s2_neg_c;
  logic [DATA_W-1:0] mag1_c, mag2_c;
  logic [DATA_W-1:0] r_nxt_c, q_nxt_c;
  logic [DATA_W-1:0] quo_fix_c, rem_fix_c;
  logic              abort_c;

  div_step #(.DATA_W(DATA_W)) u_step (
    .r_i   (r_q),
    .q_i   (q_q),
    .d_i   (d_q),
    .r_c_o (r_nxt_c),
    .q_c_o (q_nxt_c)
  );

  // Operand magnitudes and sign-corrected results
  always_comb begin
    s1_neg_c  = div.div_signed & div.div_src1[DATA_W-1];
    s2_neg_c  = div.div_signed & div.div_src2[DATA_W-1];
    mag1_c    = s1_neg_c ? DATA_W'(DATA_W'(0) - div.div_src1) : div.div_src1;
    mag2_c    = s2_neg_c ? DATA_W'(DATA_W'(0) - div.div_src2) : div.div_src2;
    quo_fix_c = op_q.q_neg ? DATA_W'(DATA_W'(0) - q_nxt_c) : q_nxt_c;
    rem_fix_c = op_q.r_neg ? DATA_W'(DATA_W'(0) - r_nxt_c) : r_nxt_c;
    abort_c   = div.div_cancel | ~div.div_req;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    op_d     = op_q;
    result_d = result_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (div.div_req && !div.div_cancel) begin
          state_d    = DIV_CALC;
          cnt_d      = '0;
          r_d        = '0;
          q_d        = mag1_c;
          d_d        = mag2_c;
          op_d.q_neg = s1_neg_c ^ s2_neg_c;
          op_d.r_neg = s1_neg_c;
          op_d.rem   = div.div_rem;
        end
      end
      DIV_CALC: begin
        if (abort_c) begin
          state_d = DIV_IDLE;
        end else begin
          r_d   = r_nxt_c;
          q_d   = q_nxt_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = DIV_DONE;
            result_d = op_q.rem ? rem_fix_c : quo_fix_c;
          end
        end
      end
      DIV_DONE: begin
        // A req seen in the firing cycle belongs to the retiring instruction
        if (abort_c || div.mem_allowin) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    busy_d = (state_d == DIV_CALC);
    done_d = (state_d == DIV_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign div.div_busy   = busy_q;
  assign div.div_done   = done_q;
  assign div.div_result = result_q;

endmodule

// File: tb/tb_exe_div_ctrl.sv
// Directed and randomized checks of exe_div_ctrl against a magnitude-arithmetic model.
module tb_exe_div_ctrl;

  localparam int unsigned W = 32;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  exe_div_ctrl_if #(.DATA_W(W)) bus ();

  exe_div_ctrl #(.DATA_W(W), .CNT_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .div    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Truncating division on magnitudes; x/0 gives all-ones quotient, remainder = dividend
  function automatic logic [W-1:0] ref_div(input bit sgn, input bit rem,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    bit           an, bn;
    logic [W-1:0] ma, mb, mq, mr;
    an = sgn && a[W-1];
    bn = sgn && b[W-1];
    ma = an ? W'(0 - a) : a;
    mb = bn ? W'(0 - b) : b;
    if (mb == 0) begin
      mq = '1;
      mr = ma;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    if (rem) return an ? W'(0 - mr) : mr;
    return (an ^ bn) ? W'(0 - mq) : mq;
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge
  task automatic accept(input bit sgn, input bit rem, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.div_req    = 1'b1;
    bus.div_signed = sgn;
    bus.div_rem    = rem;
    bus.div_src1   = a;
    bus.div_src2   = b;
    @(posedge clk); #1;
    bus.div_src1 = $urandom;
    bus.div_src2 = $urandom;
  endtask

  task automatic run_div(input string tag, input bit sgn, input bit rem,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int hold);
    int           lat;
    int           busy_n;
    int           unstable;
    logic [W-1:0] res;
    accept(sgn, rem, a, b);
    lat    = 0;
    busy_n = 0;
    while (!bus.div_done && lat < 100) begin
      if (bus.div_busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    // Acceptance cycle is cycle 0, so done is first seen in cycle lat+1
    check({tag, ".done_cycle"}, W'(lat + 1), W'(33));
    check({tag, ".busy_cycles"}, W'(busy_n), W'(32));
    check({tag, ".result"}, bus.div_result, exp);
    res      = bus.div_result;
    unstable = 0;
    bus.mem_allowin = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!bus.div_done || bus.div_result !== res) unstable++;
    end
    if (hold > 0) check({tag, ".hold_unstable"}, W'(unstable), W'(0));
    bus.mem_allowin = 1'b1;
    @(posedge clk); #1;
    check({tag, ".done_after_fire"}, W'(bus.div_done), W'(0));
    bus.mem_allowin = 1'b0;
    bus.div_req     = 1'b0;
  endtask

  initial begin
    int           seen_done;
    bit           sgn, rem;
    logic [W-1:0] a, b;

    checks = 0;
    errors = 0;
    resetn          = 1'b0;
    bus.div_req     = 1'b0;
    bus.div_signed  = 1'b0;
    bus.div_rem     = 1'b0;
    bus.div_src1    = '0;
    bus.div_src2    = '0;
    bus.div_cancel  = 1'b0;
    bus.mem_allowin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", W'(bus.div_busy), W'(0));
    check("reset.done", W'(bus.div_done), W'(0));
    check("reset.result", bus.div_result, W'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases; consecutive runs are back to back
    run_div("u100div7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 0);
    run_div("u100mod7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 0);
    run_div("s-7div2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
    run_div("s-7mod2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
    run_div("s7mod-2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 0);
    run_div("s_ovf_q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_div("s_ovf_r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_div("u5div0", 1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_div("u5mod0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 10);

    // Cancel in CALC cycle 15: idle next cycle, done never shows
    accept(1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    check("cancel.busy_before", W'(bus.div_busy), W'(1));
    bus.div_cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel.busy_after", W'(bus.div_busy), W'(0));
    bus.div_cancel = 1'b0;
    bus.div_req    = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.div_done) seen_done++;
    end
    check("cancel.no_done", W'(seen_done), W'(0));
    run_div("u9div3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 0);

    // Request dropped mid-CALC behaves as cancel
    accept(1'b0, 1'b0, 32'd77, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    bus.div_req = 1'b0;
    @(posedge clk); #1;
    check("withdraw.busy", W'(bus.div_busy), W'(0));

    // Cancel and request together in IDLE: not accepted
    bus.div_req    = 1'b1;
    bus.div_cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel_req.busy", W'(bus.div_busy), W'(0));
    bus.div_req    = 1'b0;
    bus.div_cancel = 1'b0;
    @(posedge clk); #1;

    // Reset during CALC
    accept(1'b0, 1'b0, 32'd500, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_calc.busy", W'(bus.div_busy), W'(0));
    check("rst_calc.done", W'(bus.div_done), W'(0));
    check("rst_calc.result", bus.div_result, W'(0));
    resetn      = 1'b1;
    bus.div_req = 1'b0;
    @(posedge clk); #1;

    // Reset during DONE
    accept(1'b0, 1'b0, 32'd500, 32'd7);
    for (int i = 0; i < 100 && !bus.div_done; i++) begin
      @(posedge clk); #1;
    end
    check("rst_done.pre_done", W'(bus.div_done), W'(1));
    check("rst_done.pre_result", bus.div_result, W'(71));
    resetn = 1'b0;
    @(posedge clk); #1;
    check("rst_done.busy", W'(bus.div_busy), W'(0));
    check("rst_done.done", W'(bus.div_done), W'(0));
    check("rst_done.result", bus.div_result, W'(0));
    resetn      = 1'b1;
    bus.div_req = 1'b0;
    @(posedge clk); #1;

    // Randomized operands against the model
    for (int j = 0; j < 16; j++) begin
      sgn = 1'($urandom_range(0, 1));
      rem = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case (j % 4)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_div($sformatf("rand%0d", j), sgn, rem, a, b, ref_div(sgn, rem, a, b),
              (j % 5 == 0) ? 3 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
